afifo_rd_packer: RTL and testbench
==================================

Name: afifo_rd_packer

Overview:
Downstream consumer of the afifo read port, running in the afifo read-clock domain. It drives the FIFO `rd` strobe and absorbs `rd_dat`/`rd_dat_vld`, which arrive with a fixed 1-cycle read latency. It packs PACK_NUM consecutive BITWID-bit words into one wide word. The wide word goes out on a valid/ready interface, and FIFO reads are throttled so that no returned word is ever dropped.

Parameters:
BITWID, 5, width of one afifo data word
PACK_NUM, 4, words per packed output word (2..16)
PNWID, 3, width of the pack index counter; must satisfy 2^PNWID > PACK_NUM

Ports:
clk  in  1  read-side clock (same clock as afifo rd_clk)
rst_n  in  1  asynchronous active-low reset
fifo_empty  in  1  afifo empty flag, same-cycle view
fifo_rd  out  1  afifo read strobe
fifo_rd_dat  in  BITWID  afifo read data
fifo_rd_dat_vld  in  1  afifo read data valid, one cycle after fifo_rd
out_vld  out  1  packed word valid
out_rdy  in  1  downstream ready
out_dat  out  PACK_NUM*BITWID  packed word; first word in LSBs
pack_idx  out  PNWID  words currently held in the accumulator (0..PACK_NUM)

Behaviour:
- Reset values (async, rst_n low): fifo_rd=0, out_vld=0, out_dat=0, pack_idx=0, accumulator=0, rd_inflight=0. Any word returned during reset is discarded.
- rd_inflight: register set to fifo_rd each cycle. pending = pack_idx + rd_inflight.
- Read issue: fifo_rd = ~fifo_empty & (pending < PACK_NUM). This is combinational and never asserted in reset.
- Capture: when fifo_rd_dat_vld=1, the word is written to accumulator bits [pack_idx*BITWID +: BITWID] and pack_idx increments.
- A fifo_rd_dat_vld with pending==0 is a protocol error. It is ignored, and there is no state change.
- Output register is free when (~out_vld | out_rdy).
- Completion:
  - If the captured word brings pack_idx to PACK_NUM and the output register is free, then on the same edge out_dat <= completed accumulator, out_vld <= 1, pack_idx <= 0.
  - If the output register is not free, pack_idx holds at PACK_NUM (accumulator full, reads stalled).
- Held transfer: if pack_idx==PACK_NUM and the output register is free, then out_dat <= accumulator, out_vld <= 1, pack_idx <= 0.
- Handshake:
  - The transfer fires when out_vld & out_rdy.
  - out_vld clears on transfer unless a new word loads on that same edge; in that case out_vld stays 1 with the new data.
  - out_dat is stable while out_vld & ~out_rdy.
- Throughput: PACK_NUM words per PACK_NUM+1 cycles maximum, with one bubble per pack from the pending rule.
- Ordering: strict FIFO order. No word is lost or duplicated, including under arbitrary out_rdy and fifo_empty patterns.
- Storage bound: at most 2*PACK_NUM words held (output register plus accumulator).
- Reset mid-operation: partial and held words are discarded. Reset must be applied together with the afifo read-side reset.

Optional Feature:
Macro: AFIFO_PACK_FLUSH_EN.
- Defined:
  - Adds input flush (1 bit, pulse) and output out_num (PNWID, number of valid words in out_dat).
  - flush is accepted when pack_idx>0 & rd_inflight==0 & output register free. The partial accumulator is emitted with unused upper slots zero, out_num=pack_idx, and pack_idx <= 0.
  - A flush that is not accepted stays pending internally until accepted, or is dropped if pack_idx returns to 0.
  - fifo_rd is blocked while a flush is pending.
  - Full packs give out_num=PACK_NUM.
- Undefined: no flush or out_num ports; partial words wait for completion.

Test Plan:
1. Basic pack: write 1,2,3,4 to the afifo, out_rdy=1. Expect out_vld for 1 cycle with out_dat=0x20C41, and fifo_rd asserted exactly 4 times.
2. Backpressure: 12 words queued, out_rdy=0. Expect the first pack in out_dat, pack_idx=4, fifo_rd stuck 0 after exactly 8 reads. On out_rdy=1, expect 3 packs in order and 12 reads total.
3. Empty starvation: 3 words then fifo_empty=1 for 50 cycles. Expect fifo_rd=0, pack_idx=3, out_vld=0. The 4th word completes the pack, and out_vld rises the next cycle.
4. Simultaneous: out_vld=1 with out_rdy=1 on the same edge a pack completes. Expect out_vld to stay 1, the new out_dat present, and no bubble or loss.
5. Reset mid-op: pack_idx=2 with a read in flight, pull rst_n low asynchronously. Expect out_vld=0, pack_idx=0, fifo_rd=0 immediately, and no output after release until 4 fresh words arrive.
6. (AFIFO_PACK_FLUSH_EN) Words 0x1F,0x00,0x1F then a flush pulse. Expect out_dat=0x07C1F, out_num=3, and pack_idx back to 0.

Source files
------------

// File: rtl/afifo_rd_packer.sv
// afifo_rd_packer: reads an afifo (1-cycle read latency) and packs PACK_NUM words into one wide word.
// Optional partial-pack flush with an out_num word count is compiled in by defining AFIFO_PACK_FLUSH_EN.
module afifo_rd_packer #(
  parameter int BITWID   = 5,
  parameter int PACK_NUM = 4,
  parameter int PNWID    = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
`ifdef AFIFO_PACK_FLUSH_EN
  input  logic                       flush,
  output logic [PNWID-1:0]           out_num,
`endif
  input  logic                       fifo_empty,
  output logic                       fifo_rd,
  input  logic [BITWID-1:0]          fifo_rd_dat,
  input  logic                       fifo_rd_dat_vld,
  output logic                       out_vld,
  input  logic                       out_rdy,
  output logic [PACK_NUM*BITWID-1:0] out_dat,
  output logic [PNWID-1:0]           pack_idx
);

  localparam int                 DW        = PACK_NUM * BITWID;
  localparam logic [PNWID-1:0]   FULL_IDX  = PNWID'(PACK_NUM);
  localparam logic [PNWID:0]     FULL_PEND = (PNWID+1)'(PACK_NUM);

  logic             rd_inflight_q;
  logic [PNWID-1:0] pack_idx_q, pack_idx_d;
  logic [DW-1:0]    acc_q, acc_d;
  logic [DW-1:0]    out_dat_q, out_dat_d;
  logic             out_vld_q, out_vld_d;

  logic [PNWID:0]   pending;
  logic             capture;
  logic             out_free;
  logic             load;
  logic             emit;
  logic             rd_allow;
  logic [PNWID-1:0] idx_cap;
  logic [DW-1:0]    acc_cap;

`ifdef AFIFO_PACK_FLUSH_EN
  logic             flush_pend_q, flush_pend_d;
  logic [PNWID-1:0] out_num_q, out_num_d;
  logic             flush_req;
  logic             flush_acc;
`endif

  // Words already held plus the one still in flight; reads stop once a full pack is committed.
  assign pending  = {1'b0, pack_idx_q} + {{PNWID{1'b0}}, rd_inflight_q};
  assign capture  = fifo_rd_dat_vld & (pending != '0) & (pack_idx_q < FULL_IDX);
  // Output handshake: a word transfers on any edge where out_vld & out_rdy; while out_vld is
  // high and out_rdy low, out_dat is held. The output register may reload when ~out_vld | out_rdy.
  assign out_free = ~out_vld_q | out_rdy;

  always_comb begin
    acc_cap = acc_q;
    for (int i = 0; i < PACK_NUM; i++) begin
      if (capture && (pack_idx_q == PNWID'(i))) begin
        acc_cap[i*BITWID +: BITWID] = fifo_rd_dat;
      end
    end
    idx_cap = pack_idx_q + {{(PNWID-1){1'b0}}, capture};
    // Covers both a pack completing on this edge and a full pack that was waiting for space.
    load    = out_free & (idx_cap == FULL_IDX);
`ifdef AFIFO_PACK_FLUSH_EN
    flush_req = flush | flush_pend_q;
    flush_acc = flush_req & (pack_idx_q != '0) & ~rd_inflight_q & out_free & ~load;
    emit      = load | flush_acc;
`else
    emit      = load;
`endif
    pack_idx_d = emit ? '0 : idx_cap;
    acc_d      = emit ? '0 : acc_cap;
    out_dat_d  = emit ? acc_cap : out_dat_q;
    out_vld_d  = emit | (out_vld_q & ~out_rdy);
`ifdef AFIFO_PACK_FLUSH_EN
    out_num_d    = emit ? idx_cap : out_num_q;
    flush_pend_d = flush_req & ~flush_acc & (pack_idx_d != '0);
    rd_allow     = rst_n & ~fifo_empty & (pending < FULL_PEND) & ~flush_pend_q;
`else
    rd_allow     = rst_n & ~fifo_empty & (pending < FULL_PEND);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_inflight_q <= 1'b0;
      pack_idx_q    <= '0;
      acc_q         <= '0;
      out_dat_q     <= '0;
      out_vld_q     <= 1'b0;
`ifdef AFIFO_PACK_FLUSH_EN
      flush_pend_q  <= 1'b0;
      out_num_q     <= '0;
`endif
    end else begin
      rd_inflight_q <= rd_allow;
      pack_idx_q    <= pack_idx_d;
      acc_q         <= acc_d;
      out_dat_q     <= out_dat_d;
      out_vld_q     <= out_vld_d;
`ifdef AFIFO_PACK_FLUSH_EN
      flush_pend_q  <= flush_pend_d;
      out_num_q     <= out_num_d;
`endif
    end
  end

  assign fifo_rd  = rd_allow;
  assign out_vld  = out_vld_q;
  assign out_dat  = out_dat_q;
  assign pack_idx = pack_idx_q;
`ifdef AFIFO_PACK_FLUSH_EN
  assign out_num  = out_num_q;
`endif

endmodule

// File: tb/tb_afifo_rd_packer.sv
// tb_afifo_rd_packer: afifo read-port model driving afifo_rd_packer, with a pack-level scoreboard.
// Define AFIFO_PACK_FLUSH_EN to also exercise the flush / out_num path.
`timescale 1ns/1ps
module tb_afifo_rd_packer;

  localparam int BITWID   = 5;
  localparam int PACK_NUM = 4;
  localparam int PNWID    = 3;
  localparam int PW       = PACK_NUM * BITWID;

  logic              clk;
  logic              rst_n;
  logic              fifo_empty;
  logic              fifo_rd;
  logic [BITWID-1:0] fifo_rd_dat;
  logic              fifo_rd_dat_vld;
  logic              out_vld;
  logic              out_rdy;
  logic [PW-1:0]     out_dat;
  logic [PNWID-1:0]  pack_idx;
`ifdef AFIFO_PACK_FLUSH_EN
  logic              flush;
  logic [PNWID-1:0]  out_num;
`endif

  afifo_rd_packer #(.BITWID(BITWID), .PACK_NUM(PACK_NUM), .PNWID(PNWID)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
`ifdef AFIFO_PACK_FLUSH_EN
    .flush           (flush),
    .out_num         (out_num),
`endif
    .fifo_empty      (fifo_empty),
    .fifo_rd         (fifo_rd),
    .fifo_rd_dat     (fifo_rd_dat),
    .fifo_rd_dat_vld (fifo_rd_dat_vld),
    .out_vld         (out_vld),
    .out_rdy         (out_rdy),
    .out_dat         (out_dat),
    .pack_idx        (pack_idx)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model state / scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [BITWID-1:0] fq[$];
  logic [BITWID-1:0] part[$];
  logic [PW-1:0]     exp_q[$];
  int                exp_n_q[$];
  int reads      = 0;
  int fires      = 0;
  int vld_cycles = 0;
  int held       = 0;
  logic [PW-1:0] last_fire_dat = '0;
  logic starve;
  int r0, f0, v0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] pack_part();
    logic [PW-1:0] pk;
    pk = '0;
    for (int i = 0; i < part.size(); i++) pk[i*BITWID +: BITWID] = part[i];
    return pk;
  endfunction

  task automatic push_word(input logic [BITWID-1:0] w);
    fq.push_back(w);
  endtask

  task automatic push(input int n);
    for (int i = 0; i < n; i++) fq.push_back(BITWID'($urandom));
  endtask

  // One clock: inputs and samples at the falling edge, read data returned just after the rising edge.
  task automatic tick();
    logic [BITWID-1:0] w;
    logic rd_now;
    w = BITWID'($urandom);
    @(negedge clk);
    fifo_empty = starve || (fq.size() == 0);
    #1;
    rd_now = fifo_rd;
    check("rd_on_empty", 64'(fifo_rd & fifo_empty), 64'd0);
    check("vld_without_pack", 64'(out_vld && (exp_q.size() == 0)), 64'd0);
    if (out_vld && (exp_q.size() != 0)) begin
      vld_cycles++;
      check("out_dat", 64'(out_dat), 64'(exp_q[0]));
`ifdef AFIFO_PACK_FLUSH_EN
      check("out_num", 64'(out_num), 64'(exp_n_q[0]));
`endif
      if (out_rdy) begin
        last_fire_dat = out_dat;
        held -= exp_n_q.pop_front();
        void'(exp_q.pop_front());
        fires++;
      end
    end
    if (rd_now && (fq.size() != 0)) begin
      w = fq.pop_front();
      reads++;
      held++;
      part.push_back(w);
      if (part.size() == PACK_NUM) begin
        exp_q.push_back(pack_part());
        exp_n_q.push_back(PACK_NUM);
        part.delete();
      end
    end
    check("held_words_bound", 64'(held > 2*PACK_NUM), 64'd0);
    @(posedge clk);
    #1;
    fifo_rd_dat_vld = rd_now;
    fifo_rd_dat     = w;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    logic done;
    n      = 0;
    starve = 1'b0;
    out_rdy = 1'b1;
    done   = 1'b0;
    while (!done && (n < budget)) begin
      tick();
      n++;
      done = (fq.size() == 0) && (exp_q.size() == 0) && !out_vld;
    end
    check(tag, 64'(done), 64'd1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst_n = 1'b0; fifo_empty = 1'b1; fifo_rd_dat_vld = 1'b0; fifo_rd_dat = '0;
    out_rdy = 1'b0; starve = 1'b0;
`ifdef AFIFO_PACK_FLUSH_EN
    flush = 1'b0;
`endif
    // Reset values, read strobe gated and returned data ignored while in reset.
    #3;
    check("rst_out_vld", 64'(out_vld), 64'd0);
    check("rst_out_dat", 64'(out_dat), 64'd0);
    check("rst_pack_idx", 64'(pack_idx), 64'd0);
    fifo_empty = 1'b0; fifo_rd_dat_vld = 1'b1; fifo_rd_dat = 5'h1F;
    #1;
    check("rst_fifo_rd", 64'(fifo_rd), 64'd0);
    @(posedge clk); #1;
    check("rst_discard", 64'(pack_idx), 64'd0);
    @(negedge clk);
    rst_n = 1'b1; fifo_rd_dat_vld = 1'b0; fifo_empty = 1'b1;
    @(posedge clk); #1;
    check("post_rst_idx", 64'(pack_idx), 64'd0);

    // 1. Basic pack 1,2,3,4.
    out_rdy = 1'b1; r0 = reads; v0 = vld_cycles;
    push_word(5'd1); push_word(5'd2); push_word(5'd3); push_word(5'd4);
    drain("t1_drain", 40);
    check("t1_reads", 64'(reads - r0), 64'd4);
    check("t1_vld_cycles", 64'(vld_cycles - v0), 64'd1);
    check("t1_dat", 64'(last_fire_dat), 64'h20C41);

    // 2. Backpressure with 12 words queued.
    out_rdy = 1'b0; r0 = reads; f0 = fires;
    push(12);
    repeat (30) tick();
    check("t2_reads_stalled", 64'(reads - r0), 64'd8);
    check("t2_pack_idx", 64'(pack_idx), 64'(PACK_NUM));
    check("t2_out_vld", 64'(out_vld), 64'd1);
    check("t2_fifo_rd", 64'(fifo_rd), 64'd0);
    check("t2_first_pack", 64'(out_dat), 64'(exp_q[0]));
    drain("t2_drain", 60);
    check("t2_reads_total", 64'(reads - r0), 64'd12);
    check("t2_packs", 64'(fires - f0), 64'd3);

    // 3. Starvation after 3 words.
    f0 = fires;
    push(3);
    repeat (50) tick();
    check("t3_fifo_rd", 64'(fifo_rd), 64'd0);
    check("t3_pack_idx", 64'(pack_idx), 64'd3);
    check("t3_out_vld", 64'(out_vld), 64'd0);
    push(1);
    tick();
    tick();
    check("t3_vld_next", 64'(out_vld), 64'd1);
    drain("t3_drain", 20);
    check("t3_packs", 64'(fires - f0), 64'd1);

    // 4. Transfer and reload of the output register on the same edge.
    out_rdy = 1'b0; f0 = fires;
    push(8);
    repeat (9) tick();
    check("t4_pre_vld", 64'(out_vld), 64'd1);
    check("t4_pre_idx", 64'(pack_idx), 64'd3);
    out_rdy = 1'b1;
    tick();
    check("t4_vld_stays", 64'(out_vld), 64'd1);
    check("t4_new_dat", 64'(out_dat), 64'(exp_q[0]));
    check("t4_idx", 64'(pack_idx), 64'd0);
    check("t4_first_fired", 64'(fires - f0), 64'd1);
    drain("t4_drain", 20);
    check("t4_packs", 64'(fires - f0), 64'd2);

    // 5. Asynchronous reset with pack_idx=2 and a read in flight.
    out_rdy = 1'b1;
    push(4);
    repeat (3) tick();
    check("t5_pre_idx", 64'(pack_idx), 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_vld", 64'(out_vld), 64'd0);
    check("t5_rst_idx", 64'(pack_idx), 64'd0);
    check("t5_rst_rd", 64'(fifo_rd), 64'd0);
    fq.delete(); part.delete(); exp_q.delete(); exp_n_q.delete(); held = 0;
    repeat (2) @(posedge clk);
    #1;
    check("t5_in_rst_idx", 64'(pack_idx), 64'd0);
    @(negedge clk);
    rst_n = 1'b1; fifo_rd_dat_vld = 1'b0; fifo_empty = 1'b1;
    f0 = fires;
    push(3);
    repeat (20) tick();
    check("t5_partial_idx", 64'(pack_idx), 64'd3);
    check("t5_no_output", 64'(fires - f0), 64'd0);
    push(1);
    drain("t5_drain", 20);
    check("t5_fresh_pack", 64'(fires - f0), 64'd1);

`ifdef AFIFO_PACK_FLUSH_EN
    // 6. Flush of a 3-word partial pack.
    out_rdy = 1'b1;
    push_word(5'h1F); push_word(5'h00); push_word(5'h1F);
    repeat (4) tick();
    check("t6_pre_idx", 64'(pack_idx), 64'd3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    exp_q.push_back(pack_part());
    exp_n_q.push_back(part.size());
    part.delete();
    check("t6_vld", 64'(out_vld), 64'd1);
    check("t6_dat", 64'(out_dat), 64'h07C1F);
    check("t6_num", 64'(out_num), 64'd3);
    check("t6_idx", 64'(pack_idx), 64'd0);
    drain("t6_drain", 20);
`endif

    // Randomized traffic: random fill, random out_rdy, random extra empty cycles.
    f0 = fires;
    for (int c = 0; c < 1500; c++) begin
      if (fq.size() < 16) push($urandom_range(0, 2));
      out_rdy = ($urandom_range(0, 3) != 0);
      starve  = ($urandom_range(0, 7) == 0);
      tick();
    end
    starve = 1'b0;
    push((PACK_NUM - ((part.size() + fq.size()) % PACK_NUM)) % PACK_NUM);
    drain("rand_drain", 500);
    check("rand_idle_idx", 64'(pack_idx), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
